// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single word-wide memory port between
// instruction fetch (I) and load/store (D). One transaction is in flight at a
// time. A starvation guard forces a fetch grant after STARVE_MAX consecutive
// data grants taken while fetch was waiting.
// Build option: define ARB_TIMEOUT_EN to abort a transaction (done + err) after
// TIMEOUT busy cycles without mem_ack; otherwise the arbiter waits forever.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic [DW-1:0]     i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  input  logic [DW/8-1:0]   d_wstrb,
  output logic [DW-1:0]     d_rdata,
  output logic              d_done,
  output logic              err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IBUSY = 2'd1;
  localparam logic [1:0] ST_DBUSY = 2'd2;

  // Word-aligns every address presented to memory.
  localparam logic [AW-1:0] ADDR_MASK  = {{(AW-2){1'b1}}, 2'b00};
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state;
  logic [3:0] starve;
  logic       busy;
  logic       grant_d;
  logic       finish;
  logic       abort;

  assign busy    = (state != ST_IDLE);
  // Data wins unless fetch is waiting and has already been passed over STARVE_MAX times.
  assign grant_d = d_req && (!i_req || (starve < STARVE_LIM));

`ifdef ARB_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  // Abort fires on the TIMEOUT-th busy cycle that still has no ack.
  assign abort = busy && !mem_ack && (tmo_cnt == TO_LAST);

  // Counts ack-less busy cycles; held at zero while idle so each grant starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (!busy) begin
      tmo_cnt <= '0;
    end else if (!mem_ack) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign finish = busy && (mem_ack || abort);
  assign i_done = (state == ST_IBUSY) && finish;
  assign d_done = (state == ST_DBUSY) && finish;
  assign err    = abort;

  // Read data is a pass-through of the ack cycle only; stores and aborts return zero.
  assign i_rdata = ((state == ST_IBUSY) && mem_ack) ? mem_rdata : '0;
  assign d_rdata = ((state == ST_DBUSY) && mem_ack && !mem_we) ? mem_rdata : '0;

  // The pipeline may advance in the completion cycle if nobody else is waiting.
  assign stall = (i_req || d_req || busy)
                 && !((i_done && !d_req) || (d_done && !i_req));

  // Grant sequencing: latch the winner onto the memory port, hold until ack or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      starve    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state     <= ST_DBUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr & ADDR_MASK;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_we ? d_wstrb : '0;
            if (i_req && (starve != 4'hF)) begin
              starve <= starve + 4'd1;
            end
          end else if (i_req) begin
            state     <= ST_IBUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr & ADDR_MASK;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            starve    <= '0;
          end
        end
        default: begin
          if (finish) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int SW         = DW / 8;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          err;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int checks = 0;
  int errors = 0;

  // Memory responder controls
  logic          resp_en   = 1'b0;
  logic          resp_rand = 1'b0;
  int            resp_delay = 1;
  int            wait_cnt   = 0;
  logic          man_ack   = 1'b0;
  logic [DW-1:0] man_rdata = '0;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_done(d_done),
    .err(err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: manual ack/data when disabled, otherwise acks each request after a delay.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!resp_en) begin
        mem_ack   = man_ack;
        mem_rdata = man_rdata;
        wait_cnt  = 0;
      end else if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
        if (resp_rand) resp_delay = $urandom_range(0, 3);
      end else if (mem_req) begin
        if (wait_cnt >= resp_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_wstrb, i_done, d_done, err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b we=%b strb=%h idone=%b ddone=%b err=%b, all required 0",
               mem_req, mem_we, mem_wstrb, i_done, d_done, err);
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++; $display("FAIL reset_addr: got %h required 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== '0) begin
      errors++; $display("FAIL reset_wdata: got %h required 0", mem_wdata);
    end
    checks++;
    if ({i_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_rdata: i=%h d=%h required 0", i_rdata, d_rdata);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b required 0", stall);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    tick();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({stall, mem_req} !== 2'b10) begin
      errors++; $display("FAIL fetch_pre: stall=%b mem_req=%b required 1 0", stall, mem_req);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_wstrb, i_done} !== {1'b1, 1'b0, 4'h0, 1'b0} || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL fetch_issue: req=%b we=%b strb=%h addr=%h done=%b required 1 0 0 00000100 0",
               mem_req, mem_we, mem_wstrb, mem_addr, i_done);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req, i_done, stall} !== 3'b101) begin
      errors++; $display("FAIL fetch_wait: req=%b done=%b stall=%b required 1 0 1", mem_req, i_done, stall);
    end
    tick();
    man_ack = 1'b1; man_rdata = 32'h00500093;
    @(negedge clk);
    checks++;
    if ({i_done, d_done, err, stall} !== 4'b1000) begin
      errors++; $display("FAIL fetch_done: idone=%b ddone=%b err=%b stall=%b required 1 0 0 0",
                         i_done, d_done, err, stall);
    end
    checks++;
    if (i_rdata !== 32'h00500093) begin
      errors++; $display("FAIL fetch_rdata: got %h required 00500093", i_rdata);
    end
    tick();
    man_ack = 1'b0; i_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_done, mem_req, stall} !== 3'b000) begin
      errors++; $display("FAIL fetch_after: done=%b req=%b stall=%b required 0 0 0", i_done, mem_req, stall);
    end
  endtask

  task automatic test_store();
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h203; d_wstrb = 4'b1000; d_wdata = 32'hAB000000;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_wstrb} !== {1'b1, 1'b1, 4'b1000} || mem_addr !== 32'h200
        || mem_wdata !== 32'hAB000000) begin
      errors++;
      $display("FAIL store_issue: req=%b we=%b strb=%b addr=%h wdata=%h required 1 1 1000 00000200 ab000000",
               mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    tick();
    man_ack = 1'b1; man_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({d_done, i_done, err} !== 3'b100) begin
      errors++; $display("FAIL store_done: ddone=%b idone=%b err=%b required 1 0 0", d_done, i_done, err);
    end
    checks++;
    if (d_rdata !== '0) begin
      errors++; $display("FAIL store_rdata: got %h required 0", d_rdata);
    end
    tick();
    man_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_done, mem_req} !== 2'b00) begin
      errors++; $display("FAIL store_after: done=%b req=%b required 0 0", d_done, mem_req);
    end
  endtask

  task automatic test_starvation();
    string order = "";
    int    grants = 0;
    int    dones  = 0;
    int    idones = 0;
    logic  prev   = 1'b0;
    reset_pulse();
    resp_rand = 1'b1; resp_delay = 1; man_ack = 1'b0; resp_en = 1'b1;
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0; d_wstrb = '0;
    for (int c = 0; c < 300 && dones < 10; c++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        grants++;
        order = {order, (mem_addr == 32'h1000) ? "I" : "D"};
      end
      prev = mem_req;
      if (i_done) begin dones++; idones++; end
      if (d_done) dones++;
      tick();
      if (dones >= 10) begin i_req = 1'b0; d_req = 1'b0; end
    end
    checks++;
    if (dones != 10) begin
      errors++; $display("FAIL starve_dones: got %0d completions required 10", dones);
    end
    checks++;
    if (order != "DDDDIDDDDI") begin
      errors++; $display("FAIL starve_order: got %s required DDDDIDDDDI", order);
    end
    checks++;
    if (grants != 10 || idones != 2) begin
      errors++; $display("FAIL starve_counts: grants=%0d fetch_dones=%0d required 10 2", grants, idones);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, stall} !== 2'b00) begin
      errors++; $display("FAIL starve_drain: req=%b stall=%b required 0 0", mem_req, stall);
    end
    resp_en = 1'b0; resp_rand = 1'b0;
  endtask

  task automatic test_reset_mid();
    man_ack = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: mem_req=%b required 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, d_done} !== 2'b00) begin
      errors++; $display("FAIL rstmid_drop: req=%b ddone=%b required 0 0", mem_req, d_done);
    end
    d_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    man_ack = 1'b1; man_rdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({d_done, i_done, mem_req, stall} !== 4'b0000 || d_rdata !== '0) begin
      errors++; $display("FAIL rstmid_lateack: ddone=%b idone=%b req=%b stall=%b rdata=%h required all 0",
                         d_done, i_done, mem_req, stall, d_rdata);
    end
    tick();
    man_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: mem_req=%b required 0", mem_req);
    end
    tick();
    i_req = 1'b1; i_addr = 32'h400;
    tick();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
      errors++; $display("FAIL rstmid_regrant: req=%b addr=%h required 1 00000400", mem_req, mem_addr);
    end
    tick();
    man_ack = 1'b1; man_rdata = 32'h0BADCAFE;
    @(negedge clk);
    checks++;
    if (i_done !== 1'b1 || i_rdata !== 32'h0BADCAFE) begin
      errors++; $display("FAIL rstmid_fetch: done=%b rdata=%h required 1 0badcafe", i_done, i_rdata);
    end
    tick();
    man_ack = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_timeout();
    int bad = 0;
    man_ack = 1'b0; man_rdata = 32'hCAFEF00D;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (c < TIMEOUT) begin
        if (d_done || err || !mem_req) bad++;
      end else begin
        checks++;
        if ({d_done, err, i_done} !== 3'b110) begin
          errors++; $display("FAIL tmo_abort: ddone=%b err=%b idone=%b on busy cycle %0d required 1 1 0",
                             d_done, err, i_done, c);
        end
        checks++;
        if (d_rdata !== '0) begin
          errors++; $display("FAIL tmo_rdata: got %h required 0", d_rdata);
        end
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL tmo_early: %0d busy cycles ended early, required 0", bad);
    end
    d_req = 1'b0;
`else
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (d_done || err || !mem_req || !stall) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL notmo_wait: %0d of 100 cycles not waiting, required 0", bad);
    end
    man_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_done, err} !== 2'b10 || d_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL notmo_done: ddone=%b err=%b rdata=%h required 1 0 cafef00d",
                         d_done, err, d_rdata);
    end
    tick();
    man_ack = 1'b0; d_req = 1'b0;
`endif
    @(negedge clk);
    checks++;
    if ({mem_req, stall, d_done, err} !== 4'b0000) begin
      errors++; $display("FAIL tmo_idle: req=%b stall=%b ddone=%b err=%b required 0 0 0 0",
                         mem_req, stall, d_done, err);
    end
  endtask

  task automatic test_random();
    int            owner = 0;       // transaction in flight this cycle: 0 none, 1 fetch, 2 data
    int            next_owner = 0;  // grant expected at the coming edge
    int            starve = 0;
    int            i_gap = 0, d_gap = 0, i_wait = 0, max_wait = 0;
    int            n_grant = 0, n_done = 0;
    bit            i_fin = 0, d_fin = 0, done_now;
    logic          other, exp_stall;
    logic [AW-1:0] eaddr = '0;
    logic          ewe = 1'b0;
    logic [DW-1:0] ewdata = '0, exp_rd;
    logic [SW-1:0] ewstrb = '0;
    reset_pulse();
    resp_rand = 1'b1; resp_delay = 0; resp_en = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      // fetch requester
      if (i_fin) begin
        i_fin = 0;
        if ($urandom_range(0, 1) == 1) i_addr = {4'h1, 28'($urandom)};
        else begin i_req = 1'b0; i_gap = $urandom_range(0, 4); end
      end else if (!i_req) begin
        if (i_gap > 0) i_gap--;
        else begin i_req = 1'b1; i_addr = {4'h1, 28'($urandom)}; end
      end else if (owner != 1 && next_owner != 1 && $urandom_range(0, 15) == 0) begin
        i_req = 1'b0; i_gap = $urandom_range(0, 4);
      end
      // load/store requester
      if (d_fin || (!d_req && d_gap == 0)) begin
        if (d_fin && $urandom_range(0, 2) == 0) begin
          d_req = 1'b0; d_gap = $urandom_range(0, 3);
        end else begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = {4'h2, 28'($urandom)};
          d_wdata = $urandom; d_wstrb = SW'($urandom);
        end
        d_fin = 0;
      end else if (!d_req) begin
        d_gap--;
      end else if (owner != 2 && next_owner != 2 && $urandom_range(0, 15) == 0) begin
        d_req = 1'b0; d_gap = $urandom_range(0, 3);
      end

      @(negedge clk);
      done_now = 0;
      if (next_owner != 0) begin
        owner = next_owner; next_owner = 0; n_grant++;
        checks++;
        if ({mem_req, mem_we, mem_wstrb} !== {1'b1, ewe, ewstrb} || mem_addr !== eaddr
            || (owner == 2 && mem_wdata !== ewdata)) begin
          errors++;
          $display("FAIL rand_grant cyc %0d: owner %0d req=%b we=%b addr=%h strb=%h wdata=%h required we=%b addr=%h strb=%h wdata=%h",
                   cyc, owner, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, ewe, eaddr, ewstrb, ewdata);
        end
      end
      if (owner != 0) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== ewe || mem_addr !== eaddr || mem_wstrb !== ewstrb) begin
          errors++; $display("FAIL rand_hold cyc %0d: req=%b we=%b addr=%h strb=%h required 1 %b %h %h",
                             cyc, mem_req, mem_we, mem_addr, mem_wstrb, ewe, eaddr, ewstrb);
        end
        if (mem_ack) begin
          done_now = 1;
          checks++;
          if (i_done !== (owner == 1) || d_done !== (owner == 2) || err !== 1'b0) begin
            errors++; $display("FAIL rand_done cyc %0d: owner %0d idone=%b ddone=%b err=%b",
                               cyc, owner, i_done, d_done, err);
          end
          exp_rd = (owner == 2 && ewe) ? '0 : mem_rdata;
          checks++;
          if ((owner == 1 && i_rdata !== exp_rd) || (owner == 2 && d_rdata !== exp_rd)) begin
            errors++; $display("FAIL rand_rdata cyc %0d: owner %0d i=%h d=%h required %h",
                               cyc, owner, i_rdata, d_rdata, exp_rd);
          end
        end else begin
          checks++;
          if ({i_done, d_done, err} !== 3'b000) begin
            errors++; $display("FAIL rand_early cyc %0d: idone=%b ddone=%b err=%b required 0 0 0",
                               cyc, i_done, d_done, err);
          end
        end
      end else begin
        checks++;
        if ({mem_req, i_done, d_done, err} !== 4'b0000) begin
          errors++; $display("FAIL rand_idle cyc %0d: req=%b idone=%b ddone=%b err=%b required all 0",
                             cyc, mem_req, i_done, d_done, err);
        end
      end
      other     = (owner == 1) ? d_req : i_req;
      exp_stall = (i_req || d_req || owner != 0) && !(done_now && !other);
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("FAIL rand_stall cyc %0d: got %b required %b", cyc, stall, exp_stall);
      end
      if (done_now) begin
        if (owner == 1) i_fin = 1; else d_fin = 1;
        owner = 0; n_done++;
      end else if (owner == 0 && (i_req || d_req)) begin
        if (d_req && (!i_req || starve < STARVE_MAX)) begin
          next_owner = 2;
          if (i_req && starve < 15) starve++;
          eaddr = {d_addr[AW-1:2], 2'b00}; ewe = d_we; ewdata = d_wdata;
          ewstrb = d_we ? d_wstrb : '0;
        end else begin
          next_owner = 1; starve = 0;
          eaddr = {i_addr[AW-1:2], 2'b00}; ewe = 1'b0; ewstrb = '0;
        end
      end
      if (i_req && owner != 1 && next_owner != 1 && !i_fin) i_wait++;
      else i_wait = 0;
      if (i_wait > max_wait) max_wait = i_wait;
    end
    checks++;
    if (n_grant < 100 || (n_grant - n_done) > 1 || n_grant < n_done) begin
      errors++; $display("FAIL rand_totals: grants=%0d dones=%0d required >=100 and equal within one",
                         n_grant, n_done);
    end
    checks++;
    if (max_wait > 60) begin
      errors++; $display("FAIL rand_fetch_wait: longest fetch wait %0d cycles, required <= 60", max_wait);
    end
  endtask

  initial begin
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    test_reset();
    test_fetch();
    test_store();
    test_starvation();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
